msdf_otf_converter: RTL and testbench

MSDF_OTF_CONVERTER -- requirements
Module: msdf_otf_converter

---
 rtl/msdf_otf_converter_pkg.sv | 31 +++
 rtl/msdf_otf_converter_otf_append.sv | 34 +++
 rtl/msdf_otf_converter.sv | 107 ++++++++++
 tb/tb_msdf_otf_converter.sv | 205 ++++++++++++++++++++
 4 files changed

// File: rtl/msdf_otf_converter_pkg.sv
// Shared types for the MSDF on-the-fly converter: FSM states, signed-digit
// rail encodings and the digit decoder.
package msdf_otf_converter_pkg;

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      CONV = 2'd1,
      DONE = 2'd2
   } state_t;

   // Rail encodings {d_p, d_n}; (0,0) and (1,1) both decode to zero.
   localparam logic [1:0] SD_POS = 2'b10;
   localparam logic [1:0] SD_NEG = 2'b01;

   typedef enum logic [1:0] {
      DIG_ZERO = 2'b00,
      DIG_POS  = 2'b10,
      DIG_NEG  = 2'b01
   } digit_t;

   function automatic digit_t decode_digit(input logic p, input logic n);
      digit_t d;
      case ({p, n})
         SD_POS:  d = DIG_POS;
         SD_NEG:  d = DIG_NEG;
         default: d = DIG_ZERO;
      endcase
      return d;
   endfunction

endpackage

// File: rtl/msdf_otf_converter_otf_append.sv
// On-the-fly append of one signed digit to the Q / QM register pair
// (QM = Q - 1), using only shifts and selects.
module otf_append
   import msdf_otf_converter_pkg::*;
#(
   parameter int W = 17
) (
   input  logic [W-1:0] q_in,
   input  logic [W-1:0] qm_in,
   input  digit_t       digit,
   output logic [W-1:0] q_nxt,
   output logic [W-1:0] qm_nxt
);

   always_comb begin
      q_nxt  = {q_in[W-2:0], 1'b0};
      qm_nxt = {qm_in[W-2:0], 1'b1};
      unique case (digit)
         DIG_POS: begin
            q_nxt  = {q_in[W-2:0], 1'b1};
            qm_nxt = {q_in[W-2:0], 1'b0};
         end
         DIG_NEG: begin
            q_nxt  = {qm_in[W-2:0], 1'b1};
            qm_nxt = {qm_in[W-2:0], 1'b0};
         end
         default: begin
            q_nxt  = {q_in[W-2:0], 1'b0};
            qm_nxt = {qm_in[W-2:0], 1'b1};
         end
      endcase
   end

endmodule

// File: rtl/msdf_otf_converter.sv
// MSDF signed-digit to two's-complement converter with optional early
// termination once the word is known to be negative (ReLU use).
module msdf_otf_converter
   import msdf_otf_converter_pkg::*;
#(
   parameter int N       = 16,
   parameter bit RELU_EN = 1'b1
) (
   input  logic       clk,
   input  logic       rst,
   input  logic       start,
   input  logic       in_valid,
   input  logic       d_p,
   input  logic       d_n,
   output logic       in_ready,
   output logic [N:0] q,
   output logic       out_valid,
   output logic       neg_det,
   output logic       term
);

   localparam int CW = (N > 2) ? $clog2(N) : 1;

   state_t        state, state_nxt;
   logic [N:0]    q_reg, qm_reg;
   logic [N:0]    q_app, qm_app;
   logic [CW-1:0] cnt;
   logic          sign_seen;
   logic          term_r;
   digit_t        digit;
   logic          accept;
   logic          last_digit;
   logic          relu_kill;
   logic          finish;

   assign digit      = decode_digit(d_p, d_n);
   assign in_ready   = (state == CONV);
   // A digit arriving alongside a restart belongs to no word.
   assign accept     = in_valid && in_ready && !start;
   assign last_digit = (cnt == CW'(N - 1));
   assign relu_kill  = RELU_EN && !sign_seen && (digit == DIG_NEG);
   assign finish     = accept && (last_digit || relu_kill);

   // DONE only ever lasts one cycle, so its presence is the output pulse.
   assign out_valid  = (state == DONE);
   assign term       = out_valid && term_r;

   otf_append #(.W(N + 1)) u_append (
      .q_in   (q_reg),
      .qm_in  (qm_reg),
      .digit  (digit),
      .q_nxt  (q_app),
      .qm_nxt (qm_app)
   );

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) state <= IDLE;
      else      state <= state_nxt;
   end

   always_comb begin
      state_nxt = state;
      if (start) begin
         state_nxt = CONV;
      end else begin
         unique case (state)
            IDLE:    state_nxt = IDLE;
            CONV:    if (finish) state_nxt = DONE;
            DONE:    state_nxt = IDLE;
            default: state_nxt = IDLE;
         endcase
      end
   end

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         q_reg     <= '0;
         qm_reg    <= '1;
         cnt       <= '0;
         sign_seen <= 1'b0;
         neg_det   <= 1'b0;
         term_r    <= 1'b0;
         q         <= '0;
      end else if (start) begin
         q_reg     <= '0;
         qm_reg    <= '1;
         cnt       <= '0;
         sign_seen <= 1'b0;
         neg_det   <= 1'b0;
         term_r    <= 1'b0;
         q         <= '0;
      end else if (accept) begin
         q_reg  <= q_app;
         qm_reg <= qm_app;
         cnt    <= cnt + CW'(1);
         if (!sign_seen && (digit != DIG_ZERO)) begin
            sign_seen <= 1'b1;
            if (digit == DIG_NEG) neg_det <= 1'b1;
         end
         if (finish) begin
            q      <= relu_kill ? '0 : q_app;
            term_r <= relu_kill;
         end
      end
   end

endmodule

// File: tb/tb_msdf_otf_converter.sv
// Directed bench for msdf_otf_converter at N=4, with one ReLU instance
// and one plain two's-complement instance driven by the same stimulus.
module tb_msdf_otf_converter;

   localparam int N = 4;

   logic         clk = 1'b0;
   logic         rst;
   logic         start;
   logic         in_valid;
   logic         d_p;
   logic         d_n;

   logic         ready_r, ov_r, nd_r, tm_r;
   logic [N:0]   q_r;
   logic         ready_t, ov_t, nd_t, tm_t;
   logic [N:0]   q_t;

   int total = 0;
   int bad   = 0;

   always #5 clk = ~clk;

   msdf_otf_converter #(.N(N), .RELU_EN(1'b1)) dut_r (
      .clk(clk), .rst(rst), .start(start), .in_valid(in_valid),
      .d_p(d_p), .d_n(d_n), .in_ready(ready_r), .q(q_r),
      .out_valid(ov_r), .neg_det(nd_r), .term(tm_r)
   );

   msdf_otf_converter #(.N(N), .RELU_EN(1'b0)) dut_t (
      .clk(clk), .rst(rst), .start(start), .in_valid(in_valid),
      .d_p(d_p), .d_n(d_n), .in_ready(ready_t), .q(q_t),
      .out_valid(ov_t), .neg_det(nd_t), .term(tm_t)
   );

   // Stimulus drivers: inputs change on the falling edge, outputs are
   // observed on the following falling edge.
   task automatic do_start();
      start = 1'b1; in_valid = 1'b0;
      @(negedge clk);
      start = 1'b0;
   endtask

   task automatic send(input logic p, input logic n);
      d_p = p; d_n = n; in_valid = 1'b1;
      @(negedge clk);
      in_valid = 1'b0; d_p = 1'b0; d_n = 1'b0;
   endtask

   task automatic test_reset();
      rst = 1'b0; start = 1'b0; in_valid = 1'b0; d_p = 1'b0; d_n = 1'b0;
      @(negedge clk);
      total++; if (ready_r !== 1'b0) begin bad++; $display("FAIL rst_ready_r got %b want 0", ready_r); end
      total++; if (ov_r !== 1'b0) begin bad++; $display("FAIL rst_ov_r got %b want 0", ov_r); end
      total++; if (q_r !== 5'b00000) begin bad++; $display("FAIL rst_q_r got %b want 00000", q_r); end
      total++; if (q_t !== 5'b00000) begin bad++; $display("FAIL rst_q_t got %b want 00000", q_t); end
      total++; if (nd_r !== 1'b0 || tm_r !== 1'b0) begin bad++; $display("FAIL rst_nd_tm_r got %b%b want 00", nd_r, tm_r); end
      rst = 1'b1;
      d_p = 1'b1; in_valid = 1'b1;
      repeat (3) @(negedge clk);
      in_valid = 1'b0; d_p = 1'b0;
      total++; if (ready_r !== 1'b0 || ready_t !== 1'b0) begin bad++; $display("FAIL idle_hold_ready got %b%b want 00", ready_r, ready_t); end
      total++; if (ov_t !== 1'b0) begin bad++; $display("FAIL idle_hold_ov got %b want 0", ov_t); end
   endtask

   task automatic test_positive();
      do_start();
      total++; if (ready_r !== 1'b1) begin bad++; $display("FAIL s1_ready got %b want 1", ready_r); end
      send(1'b1, 1'b0);
      send(1'b0, 1'b1);
      send(1'b1, 1'b0);
      total++; if (ov_t !== 1'b0) begin bad++; $display("FAIL s1_early_ov got %b want 0", ov_t); end
      send(1'b0, 1'b1);
      total++; if (ov_t !== 1'b1) begin bad++; $display("FAIL s1_ov_t got %b want 1", ov_t); end
      total++; if (q_t !== 5'b00101) begin bad++; $display("FAIL s1_q_t got %b want 00101", q_t); end
      total++; if (q_r !== 5'b00101) begin bad++; $display("FAIL s1_q_r got %b want 00101", q_r); end
      total++; if (nd_t !== 1'b0 || tm_r !== 1'b0) begin bad++; $display("FAIL s1_nd_tm got %b%b want 00", nd_t, tm_r); end
      @(negedge clk);
      total++; if (ov_t !== 1'b0) begin bad++; $display("FAIL s1_ov_pulse got %b want 0", ov_t); end
      total++; if (q_t !== 5'b00101) begin bad++; $display("FAIL s1_q_hold got %b want 00101", q_t); end
      total++; if (ready_t !== 1'b0) begin bad++; $display("FAIL s1_ready_idle got %b want 0", ready_t); end
   endtask

   task automatic test_twos_complement();
      do_start();
      send(1'b0, 1'b1);
      total++; if (nd_t !== 1'b1) begin bad++; $display("FAIL s2_nd_t_early got %b want 1", nd_t); end
      total++; if (ov_r !== 1'b1 || tm_r !== 1'b1) begin bad++; $display("FAIL s2_relu_term got %b%b want 11", ov_r, tm_r); end
      total++; if (ov_t !== 1'b0) begin bad++; $display("FAIL s2_ov_t_early got %b want 0", ov_t); end
      send(1'b1, 1'b0);
      send(1'b0, 1'b0);
      send(1'b0, 1'b0);
      total++; if (ov_t !== 1'b1) begin bad++; $display("FAIL s2_ov_t got %b want 1", ov_t); end
      total++; if (q_t !== 5'b11100) begin bad++; $display("FAIL s2_q_t got %b want 11100", q_t); end
      total++; if (nd_t !== 1'b1 || tm_t !== 1'b0) begin bad++; $display("FAIL s2_nd_tm_t got %b%b want 10", nd_t, tm_t); end
      total++; if (ov_r !== 1'b0 || q_r !== 5'b00000) begin bad++; $display("FAIL s2_relu_ignored got ov=%b q=%b want ov=0 q=00000", ov_r, q_r); end
      @(negedge clk);
   endtask

   task automatic test_relu();
      do_start();
      send(1'b0, 1'b0);
      total++; if (ov_r !== 1'b0 || nd_r !== 1'b0) begin bad++; $display("FAIL s3_zero got ov=%b nd=%b want 0 0", ov_r, nd_r); end
      send(1'b0, 1'b1);
      total++; if (ov_r !== 1'b1 || tm_r !== 1'b1) begin bad++; $display("FAIL s3_term got ov=%b term=%b want 1 1", ov_r, tm_r); end
      total++; if (q_r !== 5'b00000 || nd_r !== 1'b1) begin bad++; $display("FAIL s3_q_nd got q=%b nd=%b want 00000 1", q_r, nd_r); end
      total++; if (ov_t !== 1'b0 || nd_t !== 1'b1) begin bad++; $display("FAIL s3_plain got ov=%b nd=%b want 0 1", ov_t, nd_t); end
      send(1'b1, 1'b0);
      total++; if (ov_r !== 1'b0 || tm_r !== 1'b0) begin bad++; $display("FAIL s3_pulse got ov=%b term=%b want 0 0", ov_r, tm_r); end
      send(1'b1, 1'b0);
      total++; if (ov_r !== 1'b0 || q_r !== 5'b00000 || nd_r !== 1'b1) begin bad++; $display("FAIL s3_ignored got ov=%b q=%b nd=%b want 0 00000 1", ov_r, q_r, nd_r); end
      total++; if (ov_t !== 1'b1 || q_t !== 5'b11111 || tm_t !== 1'b0) begin bad++; $display("FAIL s3_plain_q got ov=%b q=%b term=%b want 1 11111 0", ov_t, q_t, tm_t); end
      @(negedge clk);
   endtask

   task automatic test_gaps();
      do_start();
      send(1'b1, 1'b1);
      for (int i = 0; i < 2; i++) begin
         @(negedge clk);
         total++; if (ready_r !== 1'b1 || ready_t !== 1'b1) begin bad++; $display("FAIL s4_gap_ready got %b%b want 11", ready_r, ready_t); end
      end
      send(1'b0, 1'b0);
      @(negedge clk);
      total++; if (ov_t !== 1'b0) begin bad++; $display("FAIL s4_gap_ov got %b want 0", ov_t); end
      send(1'b0, 1'b0);
      repeat (3) @(negedge clk);
      total++; if (ready_t !== 1'b1) begin bad++; $display("FAIL s4_long_gap_ready got %b want 1", ready_t); end
      send(1'b1, 1'b0);
      total++; if (ov_r !== 1'b1 || q_r !== 5'b00001) begin bad++; $display("FAIL s4_q_r got ov=%b q=%b want 1 00001", ov_r, q_r); end
      total++; if (q_t !== 5'b00001 || nd_t !== 1'b0) begin bad++; $display("FAIL s4_q_t got q=%b nd=%b want 00001 0", q_t, nd_t); end
      @(negedge clk);
   endtask

   task automatic test_reset_mid();
      do_start();
      send(1'b1, 1'b0);
      send(1'b1, 1'b0);
      #2 rst = 1'b0;
      #1;
      total++; if (ready_r !== 1'b0 || ready_t !== 1'b0) begin bad++; $display("FAIL s5_async_ready got %b%b want 00", ready_r, ready_t); end
      total++; if (q_t !== 5'b00000) begin bad++; $display("FAIL s5_async_q got %b want 00000", q_t); end
      @(negedge clk);
      rst = 1'b1;
      d_p = 1'b1; in_valid = 1'b1;
      for (int i = 0; i < 5; i++) begin
         @(negedge clk);
         total++; if (ov_r !== 1'b0 || ov_t !== 1'b0) begin bad++; $display("FAIL s5_no_ov got %b%b want 00", ov_r, ov_t); end
      end
      in_valid = 1'b0; d_p = 1'b0;
      do_start();
      for (int i = 0; i < N; i++) send(1'b1, 1'b0);
      total++; if (ov_t !== 1'b1 || q_t !== 5'b01111) begin bad++; $display("FAIL s5_q_t got ov=%b q=%b want 1 01111", ov_t, q_t); end
      total++; if (ov_r !== 1'b1 || q_r !== 5'b01111) begin bad++; $display("FAIL s5_q_r got ov=%b q=%b want 1 01111", ov_r, q_r); end
      @(negedge clk);
   endtask

   task automatic test_restart();
      do_start();
      send(1'b1, 1'b0);
      send(1'b1, 1'b0);
      send(1'b1, 1'b0);
      // Restart with a digit on the rails; it must not enter the new word.
      start = 1'b1; in_valid = 1'b1; d_p = 1'b1; d_n = 1'b0;
      @(negedge clk);
      start = 1'b0; in_valid = 1'b0; d_p = 1'b0;
      total++; if (ov_t !== 1'b0 || ready_t !== 1'b1) begin bad++; $display("FAIL s6_restart got ov=%b ready=%b want 0 1", ov_t, ready_t); end
      send(1'b0, 1'b0);
      send(1'b0, 1'b0);
      send(1'b0, 1'b0);
      total++; if (ov_t !== 1'b0) begin bad++; $display("FAIL s6_early_ov got %b want 0", ov_t); end
      send(1'b0, 1'b1);
      total++; if (ov_t !== 1'b1 || q_t !== 5'b11111) begin bad++; $display("FAIL s6_q_t got ov=%b q=%b want 1 11111", ov_t, q_t); end
      total++; if (nd_t !== 1'b1 || tm_t !== 1'b0) begin bad++; $display("FAIL s6_nd_tm_t got %b%b want 10", nd_t, tm_t); end
      total++; if (ov_r !== 1'b1 || tm_r !== 1'b1 || q_r !== 5'b00000) begin bad++; $display("FAIL s6_relu got ov=%b term=%b q=%b want 1 1 00000", ov_r, tm_r, q_r); end
   endtask

   task automatic test_back_to_back();
      // Still in the DONE cycle of the previous word: restart immediately.
      do_start();
      total++; if (nd_r !== 1'b0 || nd_t !== 1'b0) begin bad++; $display("FAIL b2b_nd_clear got %b%b want 00", nd_r, nd_t); end
      total++; if (ready_t !== 1'b1) begin bad++; $display("FAIL b2b_ready got %b want 1", ready_t); end
      send(1'b1, 1'b0);
      send(1'b0, 1'b0);
      send(1'b1, 1'b1);
      send(1'b0, 1'b0);
      total++; if (ov_t !== 1'b1 || q_t !== 5'b01000) begin bad++; $display("FAIL b2b_q_t got ov=%b q=%b want 1 01000", ov_t, q_t); end
      total++; if (ov_r !== 1'b1 || q_r !== 5'b01000 || tm_r !== 1'b0) begin bad++; $display("FAIL b2b_q_r got ov=%b q=%b term=%b want 1 01000 0", ov_r, q_r, tm_r); end
      @(negedge clk);
   endtask

   initial begin
      test_reset();
      test_positive();
      test_twos_complement();
      test_relu();
      test_gaps();
      test_reset_mid();
      test_restart();
      test_back_to_back();
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
